// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
//   Shared types and constants for the machine-mode trap controller:
//   FSM state encoding, mcause codes for exception and interrupt lines,
//   interrupt priority order and the latched trap CSR record.
//   No ports.
package trap_ctrl_pkg;

  localparam int TRAP_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_MRET_FLUSH = 2'd2,
    ST_REDIRECT   = 2'd3
  } trap_state_e;

  // Exception request bit i reports mcause code EXC_CODE[i].
  localparam logic [4:0] EXC_CODE [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};

  // Interrupt line i reports mcause code IRQ_CODE[i] (soft, timer, ext).
  localparam logic [4:0] IRQ_CODE [3] = '{5'd3, 5'd7, 5'd11};

  // Interrupt lines listed from highest to lowest priority: ext, soft, timer.
  localparam int IRQ_PRIO_LINE [3] = '{2, 0, 1};

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic [TRAP_XLEN-1:0] mepc;
    logic [TRAP_XLEN-1:0] mcause;
    logic [TRAP_XLEN-1:0] mtval;
  } trap_csr_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// trap_ctrl_prio_enc
//   Fixed-priority encoder: the lowest-index asserted request wins.
//   Ports:
//     req   in  N   request vector
//     valid out 1   any request asserted
//     idx   out IW  index of the winning request (0 when none)
module trap_ctrl_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest asserted index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Machine-mode trap controller. Arbitrates synchronous exceptions and
//   interrupts, owns mepc/mcause/mtval and mstatus MIE/MPIE/MPP, sequences
//   pipeline flush and a ready/valid PC redirect to fetch, and executes MRET.
//   Build option: TRAP_VECTORED_EN enables MTVEC vectored mode (mode 1) for
//   interrupts; without it the mode bits are ignored and all traps go to base.
//   Ports:
//     CLK, RSTn (synchronous, active-low), EN
//     EXC_REQ/EXC_PC/EXC_TVAL     exception request, faulting PC, trap value
//     IRQ_PEND/IRQ_PC             pending interrupts, PC of next retiring instr
//     MRET_DETECTED               MRET pulse from decode
//     MTVEC                       trap vector base + mode
//     REDIRECT_READY/VALID/PC     redirect handshake to fetch
//     FLUSH                       kill younger instructions (one cycle)
//     MEPC_o/MCAUSE_o/MTVAL_o     trap CSRs
//     MSTATUS_MIE/MPIE/MPP        mstatus trap fields
//     TRAP_BUSY                   controller not idle
//
//   state       | meaning
//   ST_IDLE     | waiting for exception, interrupt or MRET
//   ST_FLUSH    | trap accepted; flush pipeline, compute trap target
//   ST_MRET_FLUSH | MRET accepted; flush pipeline, restore mstatus
//   ST_REDIRECT | present redirect to fetch until accepted
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN    = TRAP_XLEN,
  parameter int NUM_EXC = 8,
  parameter int NUM_IRQ = 3
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic [NUM_EXC-1:0] EXC_REQ,
  input  logic [XLEN-1:0]    EXC_PC,
  input  logic [XLEN-1:0]    EXC_TVAL,
  input  logic [NUM_IRQ-1:0] IRQ_PEND,
  input  logic [XLEN-1:0]    IRQ_PC,
  input  logic               MRET_DETECTED,
  input  logic [XLEN-1:0]    MTVEC,
  input  logic               REDIRECT_READY,
  output logic               FLUSH,
  output logic               REDIRECT_VALID,
  output logic [XLEN-1:0]    REDIRECT_PC,
  output logic [XLEN-1:0]    MEPC_o,
  output logic [XLEN-1:0]    MCAUSE_o,
  output logic [XLEN-1:0]    MTVAL_o,
  output logic               MSTATUS_MIE,
  output logic               MSTATUS_MPIE,
  output logic [1:0]         MSTATUS_MPP,
  output logic               TRAP_BUSY
);

  localparam int EXC_IW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
  localparam int IRQ_IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e       state_q, state_d;
  trap_csr_t         csr_q;
  logic              mie_q, mpie_q;
  logic [1:0]        mpp_q;
  logic [XLEN-1:0]   redirect_pc_q;

  logic              exc_valid, irq_valid;
  logic [EXC_IW-1:0] exc_idx;
  logic [IRQ_IW-1:0] irq_idx;
  logic [NUM_IRQ-1:0] irq_ordered;
  logic              take_exc, take_irq, take_mret;
  logic [XLEN-1:0]   exc_cause, irq_cause;
  logic [XLEN-1:0]   mtvec_base, trap_target;

  // Reorder interrupt lines so the encoder's lowest-index-wins rule yields ext > soft > timer.
  always_comb begin
    irq_ordered = '0;
    for (int k = 0; k < NUM_IRQ; k++) irq_ordered[k] = IRQ_PEND[IRQ_PRIO_LINE[k]];
  end

  trap_ctrl_prio_enc #(.N(NUM_EXC), .IW(EXC_IW)) u_exc_enc (
    .req   (EXC_REQ),
    .valid (exc_valid),
    .idx   (exc_idx)
  );

  trap_ctrl_prio_enc #(.N(NUM_IRQ), .IW(IRQ_IW)) u_irq_enc (
    .req   (irq_ordered),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  assign exc_cause = {{(XLEN-5){1'b0}}, EXC_CODE[exc_idx]};
  assign irq_cause = {1'b1, {(XLEN-6){1'b0}}, IRQ_CODE[IRQ_PRIO_LINE[irq_idx]]};

  assign mtvec_base = {MTVEC[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trap_target = mtvec_base;
    if (MTVEC[1:0] == 2'b01 && csr_q.mcause[XLEN-1])
      trap_target = mtvec_base + {csr_q.mcause[XLEN-3:0], 2'b00};
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^MTVEC[1:0];
  assign trap_target       = mtvec_base;
`endif

  always_comb begin
    state_d   = state_q;
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          if (exc_valid) begin
            take_exc = 1'b1;
            state_d  = ST_FLUSH;
          end else if (irq_valid && mie_q) begin
            take_irq = 1'b1;
            state_d  = ST_FLUSH;
          end else if (MRET_DETECTED) begin
            take_mret = 1'b1;
            state_d   = ST_MRET_FLUSH;
          end
        end
      end
      ST_FLUSH, ST_MRET_FLUSH: state_d = ST_REDIRECT;
      ST_REDIRECT: if (REDIRECT_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= ST_IDLE;
      csr_q         <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= PRIV_U;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_exc) begin
        csr_q.mepc   <= {EXC_PC[XLEN-1:2], 2'b00};
        csr_q.mcause <= exc_cause;
        csr_q.mtval  <= EXC_TVAL;
      end
      if (take_irq) begin
        csr_q.mepc   <= {IRQ_PC[XLEN-1:2], 2'b00};
        csr_q.mcause <= irq_cause;
        csr_q.mtval  <= '0;
      end
      if (take_exc || take_irq) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
        mpp_q  <= PRIV_M;
      end
      // Target is taken from the CSRs latched on the accept edge.
      if (state_q == ST_FLUSH) redirect_pc_q <= trap_target;
      if (state_q == ST_MRET_FLUSH) begin
        redirect_pc_q <= csr_q.mepc;
        mie_q         <= mpie_q;
        mpie_q        <= 1'b1;
        mpp_q         <= PRIV_U;
      end
    end
  end

  assign FLUSH          = (state_q == ST_FLUSH) || (state_q == ST_MRET_FLUSH);
  assign REDIRECT_VALID = (state_q == ST_REDIRECT);
  assign REDIRECT_PC    = redirect_pc_q;
  assign MEPC_o         = csr_q.mepc;
  assign MCAUSE_o       = csr_q.mcause;
  assign MTVAL_o        = csr_q.mtval;
  assign MSTATUS_MIE    = mie_q;
  assign MSTATUS_MPIE   = mpie_q;
  assign MSTATUS_MPP    = mpp_q;
  assign TRAP_BUSY      = (state_q != ST_IDLE);

endmodule
